// File: rtl/led_pattern_sequencer.sv
// ============================================================================
// Module      : led_pattern_sequencer
// Description : Steps an 8-bit LED bus at a switch-selected rate.
//               A prescaler produces a one-cycle TICK every SLOW_DIV or
//               FAST_DIV clocks. On each TICK the FSM either increments a
//               binary count or moves a single lit bit that bounces between
//               bit 0 and bit 7.
//               Optional feature macro: SEQ_PAUSE_EN adds the PAUSE input,
//               which freezes stepping.
// Ports       : CLOCK   in  1  system clock, rising edge
//               RESET_N in  1  asynchronous active-low reset
//               SPEED   in  1  async switch, 0 = SLOW_DIV, 1 = FAST_DIV
//               MODE    in  1  async switch, 0 = binary count, 1 = bounce scan
//               PAUSE   in  1  async switch, freeze stepping (SEQ_PAUSE_EN)
//               OUT_BUS out 8  LED pattern
//               TICK    out 1  one-cycle pulse on each pattern step
//               STATE   out 2  0 COUNT, 1 SCAN_L, 2 SCAN_R
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module led_pattern_sequencer #(
  parameter int SLOW_DIV = 6_000_000,
  parameter int FAST_DIV = 1_500_000,
  parameter int CNT_W    = 23
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       SPEED,
  input  logic       MODE,
`ifdef SEQ_PAUSE_EN
  input  logic       PAUSE,
`endif
  output logic [7:0] OUT_BUS,
  output logic       TICK,
  output logic [1:0] STATE
);

  localparam logic [1:0] ST_COUNT  = 2'd0;
  localparam logic [1:0] ST_SCAN_L = 2'd1;
  localparam logic [1:0] ST_SCAN_R = 2'd2;

  localparam logic [CNT_W-1:0] C_SLOW_MAX = CNT_W'(SLOW_DIV - 1);
  localparam logic [CNT_W-1:0] C_FAST_MAX = CNT_W'(FAST_DIV - 1);

  // Two-flop synchronisers. Stage 2 is the value the rest of the logic uses.
  // r_speed_d holds the previous synced SPEED for edge detection.
  logic             r_speed_s1, r_speed_s2, r_speed_d;
  logic             r_mode_s1,  r_mode_s2;
  logic             w_paused;
  logic             w_speed_edge;
  logic [CNT_W-1:0] w_cnt_max;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_out;
  logic [1:0]       r_state;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_speed_s1 <= 1'b0;
      r_speed_s2 <= 1'b0;
      r_speed_d  <= 1'b0;
      r_mode_s1  <= 1'b0;
      r_mode_s2  <= 1'b0;
    end else begin
      r_speed_s1 <= SPEED;
      r_speed_s2 <= r_speed_s1;
      r_speed_d  <= r_speed_s2;
      r_mode_s1  <= MODE;
      r_mode_s2  <= r_mode_s1;
    end
  end

`ifdef SEQ_PAUSE_EN
  logic r_pause_s1, r_pause_s2;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pause_s1 <= 1'b0;
      r_pause_s2 <= 1'b0;
    end else begin
      r_pause_s1 <= PAUSE;
      r_pause_s2 <= r_pause_s1;
    end
  end

  assign w_paused = r_pause_s2;
`else
  assign w_paused = 1'b0;
`endif

  assign w_speed_edge = r_speed_s2 ^ r_speed_d;
  assign w_cnt_max    = r_speed_s2 ? C_FAST_MAX : C_SLOW_MAX;

  // A rate change suppresses the tick so that the new period starts cleanly
  // from zero. The divisor switches in the same cycle as the edge, so a count
  // above the new maximum never matters.
  assign TICK = (r_cnt == w_cnt_max) && !w_speed_edge && !w_paused;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt <= '0;
    end else if (w_speed_edge || TICK) begin
      r_cnt <= '0;
    end else if (!w_paused) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Pattern FSM. The scan states only ever load one-hot values, so the
  // single-lit-bit property holds by construction.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_COUNT;
      r_out   <= 8'h00;
    end else if (TICK) begin
      case (r_state)
        ST_COUNT: begin
          if (r_mode_s2) begin
            r_state <= ST_SCAN_L;
            r_out   <= 8'h01;
          end else begin
            r_out <= r_out + 8'd1;
          end
        end
        ST_SCAN_L: begin
          if (!r_mode_s2) begin
            r_state <= ST_COUNT;
            r_out   <= 8'h00;
          end else if (r_out == 8'h80) begin
            r_state <= ST_SCAN_R;
            r_out   <= 8'h40;
          end else begin
            r_out <= r_out << 1;
          end
        end
        ST_SCAN_R: begin
          if (!r_mode_s2) begin
            r_state <= ST_COUNT;
            r_out   <= 8'h00;
          end else if (r_out == 8'h01) begin
            r_state <= ST_SCAN_L;
            r_out   <= 8'h02;
          end else begin
            r_out <= r_out >> 1;
          end
        end
        default: begin
          r_state <= ST_COUNT;
          r_out   <= 8'h00;
        end
      endcase
    end
  end

  assign OUT_BUS = r_out;
  assign STATE   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
// ============================================================================
// Module      : tb_led_pattern_sequencer
// Description : Self-checking bench for led_pattern_sequencer with
//               SLOW_DIV=4 and FAST_DIV=2. The reference model tracks the
//               number of cycles remaining until the next step. It stores the
//               scan pattern as a position on the 14-step bounce cycle.
//               Build with +define+SEQ_PAUSE_EN to exercise PAUSE.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_led_pattern_sequencer;

  localparam int SLOW = 4;
  localparam int FAST = 2;

  logic       CLOCK = 1'b0;
  logic       RESET_N = 1'b1;
  logic       SPEED = 1'b0;
  logic       MODE = 1'b0;
  logic       pause_in = 1'b0;
  logic [7:0] OUT_BUS;
  logic       TICK;
  logic [1:0] STATE;

  int vectors = 0;
  int miscompares = 0;

  led_pattern_sequencer #(
    .SLOW_DIV(SLOW),
    .FAST_DIV(FAST),
    .CNT_W   (3)
  ) dut (
    .CLOCK  (CLOCK),
    .RESET_N(RESET_N),
    .SPEED  (SPEED),
    .MODE   (MODE),
`ifdef SEQ_PAUSE_EN
    .PAUSE  (pause_in),
`endif
    .OUT_BUS(OUT_BUS),
    .TICK   (TICK),
    .STATE  (STATE)
  );

  always #5 CLOCK = ~CLOCK;

  // Reference model state.
  int         m_rem;        // cycles left until the next step, counting this one
  int         m_pos;        // bounce position: 0 = entry 01, 1..7 going left, 8..14 going right
  logic [7:0] m_out;
  logic [1:0] m_state;
  logic       m_spd_prev;
  logic       h_spd1, h_spd2, h_mode1, h_mode2, h_pause1, h_pause2;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] scan_value(input int p);
    if (p <= 7) return 8'(1 << p);
    return 8'(1 << (14 - p));
  endfunction

  task automatic model_reset();
    m_rem      = SLOW;
    m_pos      = 0;
    m_out      = 8'h00;
    m_state    = 2'd0;
    m_spd_prev = 1'b0;
    h_spd1 = 1'b0; h_spd2 = 1'b0;
    h_mode1 = 1'b0; h_mode2 = 1'b0;
    h_pause1 = 1'b0; h_pause2 = 1'b0;
  endtask

  // One clock cycle: check the DUT at the negedge, then advance the model.
  // The inputs seen by the logic in this cycle are those driven two cycles ago.
  task automatic cycle();
    logic sspd, smode, spause, edg, etick;
    @(negedge CLOCK);
    sspd   = h_spd2;
    smode  = h_mode2;
`ifdef SEQ_PAUSE_EN
    spause = h_pause2;
`else
    spause = 1'b0;
`endif
    edg    = (sspd != m_spd_prev);
    etick  = !edg && !spause && (m_rem == 1);
    check("tick",  {7'd0, TICK}, {7'd0, etick});
    check("out",   OUT_BUS, m_out);
    check("state", {6'd0, STATE}, {6'd0, m_state});
    if (edg || etick) m_rem = sspd ? FAST : SLOW;
    else if (!spause) m_rem = m_rem - 1;
    if (etick) begin
      if (!smode) begin
        if (m_state != 2'd0) begin
          m_state = 2'd0;
          m_out   = 8'h00;
        end else begin
          m_out = (m_out + 1) % 256;
        end
      end else begin
        if (m_state == 2'd0) m_pos = 0;
        else m_pos = (m_pos % 14) + 1;
        m_out   = scan_value(m_pos);
        m_state = (m_pos <= 7) ? 2'd1 : 2'd2;
      end
    end
    m_spd_prev = sspd;
    h_spd2 = h_spd1;     h_spd1 = SPEED;
    h_mode2 = h_mode1;   h_mode1 = MODE;
    h_pause2 = h_pause1; h_pause1 = pause_in;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Assert reset at an arbitrary point in the cycle and check that the outputs
  // clear with no clock edge. Hold reset, then release it between edges.
  task automatic do_reset(input int dly, input int hold);
    #(dly);
    RESET_N = 1'b0;
    #1;
    check("rst_out",   OUT_BUS, 8'h00);
    check("rst_tick",  {7'd0, TICK}, 8'h00);
    check("rst_state", {6'd0, STATE}, 8'h00);
    repeat (hold) @(posedge CLOCK);
    #3;
    check("rst_hold_out", OUT_BUS, 8'h00);
    RESET_N = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();

    // 1: reset at an arbitrary phase, then hold until the first step
    do_reset(7, 2);
    run(3);
    check("first_tick_pending", OUT_BUS, 8'h00);

    // 2: binary count through the full wrap at the slow rate
    run(257 * SLOW + 4);

    // 3: bounce scan through more than two reversals, then back to count
    MODE = 1'b1;
    run(40 * SLOW);
    MODE = 1'b0;
    run(4 * SLOW);
    check("back_to_count_state", {6'd0, STATE}, 8'h00);

    // 4: rate change in both directions at an uneven prescaler phase
    for (int i = 0; i < 8 && m_rem != 2; i++) cycle();
    SPEED = 1'b1;
    run(20);
    SPEED = 1'b0;
    run(20);

    // 5: reset while the scan is at 10 going left; restart with MODE=1
    MODE = 1'b1;
    for (int i = 0; i < 400 && !(m_out == 8'h10 && m_state == 2'd1); i++) cycle();
    check("reached_10_scan_l", OUT_BUS, 8'h10);
    do_reset(3, 2);
    run(6 * SLOW);

`ifdef SEQ_PAUSE_EN
    // 6: pause mid-period, then resume with the remaining count
    MODE = 1'b0;
    run(3 * SLOW);
    for (int i = 0; i < 8 && m_rem != 3; i++) cycle();
    pause_in = 1'b1;
    run(10);
    pause_in = 1'b0;
    run(12);
    // rate change while paused
    pause_in = 1'b1;
    run(3);
    SPEED = 1'b1;
    run(6);
    pause_in = 1'b0;
    run(10);
`endif

    // Randomised switch activity with one reset at a random phase
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 39) == 0) SPEED = ~SPEED;
      if ($urandom_range(0, 29) == 0) MODE = ~MODE;
`ifdef SEQ_PAUSE_EN
      if ($urandom_range(0, 49) == 0) pause_in = ~pause_in;
`endif
      if (i == 1200) do_reset($urandom_range(1, 7), 1);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
